// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg : shared types and constants for the UART transmit arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [7:0] LF = 8'h0A;
  localparam int DEFAULT_NUM_REQ = 2;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// rr_priority_picker : one-hot round-robin selector, search upward from ptr_i
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0] rot_valid_w;
  logic [N-1:0] rot_pick_w;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot_valid_w = N'({valid_i, valid_i} >> ptr_i);
  assign rot_pick_w  = rot_valid_w & (~rot_valid_w + N'(1));
  assign grant_o     = N'(({rot_pick_w, rot_pick_w} << ptr_i) >> N);

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin byte arbiter feeding one UART transmitter.
// Define UART_ARB_LINE_LOCK_EN to hold the line for one owner until LF/timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [8*NUM_REQ-1:0] ReqData,
  input  logic [NUM_REQ-1:0]   ReqValid,
  output logic [NUM_REQ-1:0]   ReqReady,
  output logic [7:0]           DataIn,
  output logic                 DataInValid,
  input  logic                 DataInReady,
  output logic [NUM_REQ-1:0]   Grant,
  output logic                 Busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic [NUM_REQ-1:0]   pick_w;
  logic [NUM_REQ-1:0]   ready_w;
  logic                 accept_w;
  logic [7:0]           sel_data_w;
  logic [PTR_W-1:0]     win_idx_w;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  rr_priority_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid_i (ReqValid),
    .ptr_i   (ptr_q),
    .grant_o (pick_w)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      grant_q <= '0;
`ifdef UART_ARB_LINE_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
`ifdef UART_ARB_LINE_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Output decode: ready is one-hot and already qualified by ReqValid.
  always_comb begin
    ready_w = '0;
    case (state_q)
      ST_IDLE: ready_w = pick_w;
`ifdef UART_ARB_LINE_LOCK_EN
      ST_LOCK: ready_w = grant_q & ReqValid;
`endif
      default: ready_w = '0;
    endcase
    if (Reset) ready_w = '0;
  end

  always_comb begin
    sel_data_w = 8'h00;
    win_idx_w  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready_w[i]) begin
        sel_data_w = ReqData[8*i +: 8];
        win_idx_w  = PTR_W'(i);
      end
    end
  end

  assign accept_w    = |ready_w;
  assign ReqReady    = ready_w;
  assign DataIn      = data_q;
  assign DataInValid = valid_q;
  assign Grant       = grant_q;
  assign Busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
`ifdef UART_ARB_LINE_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          state_d = ST_SEND;
          data_d  = sel_data_w;
          valid_d = 1'b1;
          grant_d = ready_w;
          ptr_d   = (win_idx_w == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_w + PTR_W'(1);
        end
      end
      ST_SEND: begin
        if (DataInReady) begin
          valid_d = 1'b0;
`ifdef UART_ARB_LINE_LOCK_EN
          if (data_q != LF) begin
            state_d = ST_LOCK;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
`else
          state_d = ST_IDLE;
          grant_d = '0;
`endif
        end
      end
`ifdef UART_ARB_LINE_LOCK_EN
      ST_LOCK: begin
        if (accept_w) begin
          state_d = ST_SEND;
          data_d  = sel_data_w;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
